// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-only synchronous data memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module lsu_subword (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRd, StExt, StMerge, StWr, StErr} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wd_q;
  logic [2:0]  f3_q;
  logic        wr_q;
  logic        accept;
  logic        f3_legal, misalign;
  logic [31:0] ext_data, merge_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign mem_addr  = {addr_q[31:2], 2'b00};

  always_comb begin
    if (req_wr) begin
      f3_legal = (req_funct3 <= 3'd2);
    end else begin
      f3_legal = (req_funct3 != 3'd3) && (req_funct3 <= 3'd5);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!f3_legal || misalign) begin
            state_d = StErr;
          end else if (req_wr && (req_funct3 == 3'd2)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = wr_q ? StMerge : StExt;
      StExt:   state_d = StIdle;
      StMerge: state_d = StIdle;
      StWr:    state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory-side outputs; combinational so reset drops mem_wr immediately
  always_comb begin
    mem_wr    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      StWr: begin
        mem_wr    = 1'b1;
        mem_wdata = wd_q;
      end
      StMerge: begin
        mem_wr    = 1'b1;
        mem_wdata = merge_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wd_q   <= '0;
      f3_q   <= '0;
      wr_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= req_addr;
      wd_q   <= req_wdata;
      f3_q   <= req_funct3;
      wr_q   <= req_wr;
    end
  end

  always_comb begin
    merge_data = mem_rdata;
    if (f3_q[1:0] == 2'b00) begin
      merge_data[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
    end else begin
      merge_data[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
    end
  end

  assign rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = '0;
    case (f3_q)
      3'd0:    ext_data = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    ext_data = {{16{rd_half[15]}}, rd_half};
      3'd2:    ext_data = mem_rdata;
      3'd4:    ext_data = {24'd0, rd_byte};
      3'd5:    ext_data = {16'd0, rd_half};
      default: ext_data = '0;
    endcase
  end

  always_comb begin
    resp_valid_d = (state_q == StExt) || (state_q == StWr) ||
                   (state_q == StMerge) || (state_q == StErr);
    resp_err_d   = (state_q == StErr);
    resp_rdata_d = (state_q == StExt) ? ext_data : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: directed plan steps plus random traffic checked against
// a byte-array memory model; a word-wide synchronous dmem sits behind the DUT.
module tb_lsu_subword;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] dmem [0:63] = '{default: 32'd0};
  logic [7:0]  ref_mem [0:255] = '{default: 8'd0};

  lsu_subword dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) dmem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= dmem[mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request end to end; expectations come from the byte-array model.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    logic        err;
    logic [31:0] eff, exp_rd, maddr, exp_maddr;
    logic [7:0]  b;
    logic [15:0] h;
    logic        got;
    int          lat, nwr, exp_lat, exp_nwr;
    err = wr ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01 && addr[0]) err = 1'b1;
    if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    eff = addr;
    if (f3[1:0] == 2'b01) eff[0] = 1'b0;
    else if (f3[1:0] == 2'b10) eff[1:0] = 2'b00;
    exp_rd    = 32'd0;
    exp_maddr = {addr[31:2], 2'b00};
    if (err) begin
      exp_lat = 2;
      exp_nwr = 0;
    end else if (!wr) begin
      exp_lat = 3;
      exp_nwr = 0;
      b = ref_mem[eff[7:0]];
      h = {ref_mem[eff[7:0] + 1], ref_mem[eff[7:0]]};
      case (f3)
        3'd0: exp_rd = {{24{b[7]}}, b};
        3'd1: exp_rd = {{16{h[15]}}, h};
        3'd2: exp_rd = {ref_mem[eff[7:0] + 3], ref_mem[eff[7:0] + 2], h};
        3'd4: exp_rd = {24'd0, b};
        default: exp_rd = {16'd0, h};
      endcase
    end else begin
      exp_lat = (f3 == 3'd2) ? 2 : 3;
      exp_nwr = 1;
      for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[eff[7:0] + i] = wd[8*i +: 8];
    end

    @(negedge clk);
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_wr     = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    nwr = 0;
    got = 1'b0;
    maddr = 32'hx;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) maddr = mem_addr;
      if (mem_wr) nwr++;
      if (resp_valid) got = 1'b1;
    end
    rd = resp_rdata;
    check("resp_seen", {31'd0, got}, 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", {31'd0, resp_err}, {31'd0, err});
    check("mem_addr", maddr, exp_maddr);
    @(negedge clk);
    if (mem_wr) nwr++;
    check("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    check("resp_rdata_clr", resp_rdata, 32'd0);
    check("resp_err_clr", {31'd0, resp_err}, 32'd0);
    check("mem_wr_cycles", 32'(nwr), 32'(exp_nwr));
    check("mem_addr_hold", mem_addr, exp_maddr);
    check("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        rw;
  logic [2:0]  rf3;
  logic [2:0]  load_f3 [0:4] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd);
    check("plan_lw_10", rd, 32'hDEADBEEF);
    do_req(1'b1, 3'd0, 32'h11, 32'h55, rd);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd);
    check("plan_lw_after_sb", rd, 32'hDEAD55EF);
    do_req(1'b1, 3'd1, 32'h12, 32'h8001, rd);
    do_req(1'b0, 3'd1, 32'h12, 32'h0, rd);
    check("plan_lh", rd, 32'hFFFF8001);
    do_req(1'b0, 3'd5, 32'h12, 32'h0, rd);
    check("plan_lhu", rd, 32'h00008001);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, rd);
    check("plan_lb", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'd2, 32'h11, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    check("plan_lw_unaligned", rd, 32'h800155EF);
`endif
    do_req(1'b0, 3'd3, 32'h10, 32'h0, rd);
    do_req(1'b1, 3'd4, 32'h10, 32'h11223344, rd);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd);
    check("plan_mem_unchanged", rd, 32'h800155EF);

    // Reset while an SB sits in its merge-write cycle
    do_req(1'b1, 3'd2, 32'h20, 32'h12345678, rd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_wr     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h21;
    req_wdata  = 32'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_merge_wr_high", {31'd0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_merge_wr_drop", {31'd0, mem_wr}, 32'd0);
    check("rst_merge_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_resp", {31'd0, resp_valid}, 32'd0);
      check("rst_hold_mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_resp", {31'd0, resp_valid}, 32'd0);
    check("rst_after_ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, rd);
    check("rst_target_unchanged", rd, 32'h12345678);

    for (int n = 0; n < 150; n++) begin
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rf3 = 3'($urandom_range(0, 7));
      else if (rw) rf3 = 3'($urandom_range(0, 2));
      else rf3 = load_f3[$urandom_range(0, 4)];
      do_req(rw, rf3, 32'($urandom_range(0, 255)), $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit sitting directly upstream of the word-only synchronous data memory, between the core's execute stage and `dmem`. It accepts one RISC-V load or store per request (LB/LH/LW/LBU/LHU/SB/SH/SW) and issues the word accesses needed to complete it:

- a single read for loads;
- a single write for SW;
- a read-modify-write for SB/SH.

It sign- or zero-extends load data and returns a single-cycle response pulse.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, request accepted on `req_valid && req_ready` at a rising edge
- `req_wr`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3 (size/sign)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (rs2), low bytes used for SB/SH
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data (stores: 0)
- `resp_err`  out  1  qualifies `resp_valid`: misaligned or illegal funct3
- `mem_wr`  out  1  to `dmem.mem_wr`
- `mem_addr`  out  32  to `dmem.addr`, always `{addr_q[31:2],2'b00}`
- `mem_wdata`  out  32  to `dmem.write_data`
- `mem_rdata`  in  32  from `dmem.read_data` (registered, valid one cycle after a read-cycle edge)

## Operation
- **States:** IDLE, RD, EXT, MERGE, WR, ERR.
- `req_ready` = (state == IDLE). Request fields are latched into `addr_q`, `f3_q`, `wd_q`, `wr_q` on accept. Ignored otherwise.
- **Legality:**
  - Loads: funct3 ∈ {0,1,2,4,5}.
  - Stores: funct3 ∈ {0,1,2}.
  - Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal or misaligned requests go IDLE→ERR. No memory access; `mem_wr` stays 0.
- **Transitions for legal requests:**
  - Load: IDLE→RD→EXT→IDLE.
  - SW: IDLE→WR→IDLE.
  - SB/SH: IDLE→RD→MERGE→IDLE.
- **Per-state memory side:**
  - RD: `mem_wr`=0.
  - WR: `mem_wr`=1, `mem_wdata`=`wd_q`.
  - MERGE: `mem_wr`=1, `mem_wdata` = `mem_rdata` with the byte lane `addr_q[1:0]` (SB) or halfword lane `addr_q[1]` (SH) replaced by `wd_q[7:0]` / `wd_q[15:0]`.
  - All other states: `mem_wr`=0, `mem_wdata`=0.
- **EXT:** select the lane from `mem_rdata` by `addr_q[1:0]`.
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- **Response:** `resp_valid`, `resp_rdata`, `resp_err` are registered. On leaving EXT, WR, MERGE or ERR: `resp_valid`=1 for exactly one cycle. `resp_err`=1 only from ERR. `resp_rdata` is nonzero only from EXT. All three return to 0 the following cycle.
- There is no response backpressure. The consumer must take the pulse.
- **Reset:** `rst_n` low asynchronously forces IDLE, clears all registers, and drops `mem_wr` immediately, so an in-flight RMW write is abandoned with memory unchanged. `req_ready` reads 1 during reset, but no request is accepted while `rst_n` is low.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
- Accept edge = E0.
- Loads and SB/SH: memory read captured at E1; response (`resp_valid`=1) visible after E2.
- SW and errors: response visible after E1.
- Back-to-back throughput:
  - Next accept at E3 for loads and SB/SH.
  - Next accept at E2 for SW and errors.
- `mem_addr` changes only at an accept edge.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses take the ERR path as above.
- Undefined:
  - Misalignment is not checked.
  - Halfword lane uses `addr_q[1]`, byte lane uses `addr_q[1:0]`, word ignores `addr_q[1:0]`.
  - Only illegal funct3 produces `resp_err`.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → store `resp_valid` one cycle after accept; load `resp_rdata`=0xDEADBEEF two cycles after accept, `resp_err`=0.
- After above: SB addr 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF. `mem_wr` high in exactly one cycle (MERGE).
- SH 0x12 data 0x8001, then LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001; LB 0x13 → 0xFFFFFF80.
- With macro: LW 0x11 → `resp_err`=1, `resp_rdata`=0, `mem_wr` never asserted, response one cycle after accept. Without macro: LW 0x11 returns word at 0x10.
- Illegal load funct3=3 and store funct3=4 → `resp_err`=1 in both builds, memory unchanged.
- Assert `rst_n` low during MERGE of an SB → `mem_wr` drops the same cycle, state IDLE, `resp_valid` never pulses, target word unchanged on later LW.
